ysyx_22051468_branch_predictor: RTL
===================================

Name: ysyx_22051468_branch_predictor

Overview:
Front-end branch predictor paired with the execute-stage branch resolution logic. IFU queries it with the fetch PC and receives a registered taken/target prediction. EXU returns each resolved conditional branch (BEQ/BNE/BLT/BGE, signed/unsigned): actual outcome, actual target, and the prediction that was used. The block trains a direct-mapped BTB with 2-bit saturating counters and issues a one-cycle PC redirect on mispredict.

Parameters:
WIDTH, 64, PC/target width
IDX_W, 4, index bits; 2**IDX_W entries (16)
TAG_W, 8, tag bits stored per entry
CNT_W, 32, mispredict statistics counter width

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  synchronous active-low reset
pred_req_valid  input  1  IFU lookup request this cycle
pred_req_pc  input  WIDTH  fetch PC of the request
pred_resp_valid  output  1  prediction valid (one cycle after the request)
pred_taken  output  1  predicted taken
pred_target  output  WIDTH  predicted next PC
upd_valid  input  1  EXU resolved a conditional branch this cycle
upd_pc  input  WIDTH  PC of the resolved branch
upd_taken  input  1  actual outcome (branch_jump from EXU)
upd_target  input  WIDTH  actual taken target
upd_pred_taken  input  1  prediction used for this branch
upd_pred_target  input  WIDTH  predicted next PC used for this branch
redirect_valid  output  1  one-cycle pulse: flush and refetch
redirect_pc  output  WIDTH  correct next PC
mispredict_cnt  output  CNT_W  saturating count of mispredicts

Behaviour:
- Reset (rst_n=0 at posedge): all entry valid bits 0, counters 2'b01, tags/targets 0; pred_resp_valid, pred_taken, redirect_valid 0; pred_target, redirect_pc, mispredict_cnt 0. Reset mid-operation drops any pending response or redirect; no output pulses in the cycle after reset is released.
- Address split: idx = pc[IDX_W+1:2], tag = pc[IDX_W+TAG_W+1:IDX_W+2]; pc[1:0] ignored.
- Lookup, latency 1: pred_req_valid at edge N → pred_resp_valid=1 during cycle N+1 only. hit = valid[idx] & tag match. pred_taken = hit & ctr[1]. pred_target = entry target if pred_taken, else pc+4 (mod 2**WIDTH). No request → pred_resp_valid=0 and the other prediction outputs hold their last value. Back-to-back requests are accepted every cycle. No backpressure.
- Update, applied at the edge where upd_valid=1:
  - Hit, taken: ctr = min(ctr+1, 3); target overwritten with upd_target.
  - Hit, not taken: ctr = max(ctr-1, 0); target unchanged.
  - Miss, taken: allocate the entry: valid=1, tag, target=upd_target, ctr=2'b10. Any old entry at that index is replaced.
  - Miss, not taken: no table change.
- Mispredict check, same edge: actual_next = upd_taken ? upd_target : upd_pc+4. pred_next = upd_pred_taken ? upd_pred_target : upd_pc+4. If they differ: redirect_valid=1 for exactly the next cycle, redirect_pc=actual_next, mispredict_cnt += 1, saturating at all-ones. If they match: redirect_valid=0 and redirect_pc holds.
- Lookup and update in the same cycle to the same index: the lookup returns pre-update contents (read-before-write). No forwarding.
- Consecutive updates are allowed every cycle. Two mispredicts in consecutive cycles produce two consecutive redirect pulses, each carrying its own PC.

Test Plan:
- Reset then lookup pc=0x8000_0000 → next cycle pred_resp_valid=1, pred_taken=0, pred_target=0x8000_0004; redirect_valid=0, mispredict_cnt=0.
- Update pc=0x8000_0010, taken=1, target=0x8000_0100, pred_taken=0 → next cycle redirect_valid=1, redirect_pc=0x8000_0100, cnt=1. Lookup 0x8000_0010 → taken=1, target=0x8000_0100.
- Same branch: 3 more taken updates (ctr saturates at 3), then 1 not-taken update (ctr=2) → lookup still predicts taken; a second not-taken update (ctr=1) → lookup predicts not taken, target=0x8000_0014.
- Aliasing: allocate 0x8000_0010, then taken update at 0x8000_0410 (same idx, different tag) → lookup 0x8000_0010 misses (not taken); lookup 0x8000_0410 hits.
- Same-cycle lookup and allocating update at 0x8000_0020 → that response is not taken; a lookup one cycle later is taken.
- Correct prediction (pred_taken=1, pred_target=upd_target) → no redirect, cnt unchanged. Assert rst_n=0 in the cycle a redirect is due → redirect_valid stays 0.

Source files
------------

// File: rtl/ysyx_22051468_branch_predictor.sv
// Direct-mapped BTB with 2-bit counters and execute-stage
// mispredict redirect; registered lookup, read-before-write.
module ysyx_22051468_branch_predictor #(
  parameter int WIDTH = 64,
  parameter int IDX_W = 4,
  parameter int TAG_W = 8,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pred_req_valid,
  input  logic [WIDTH-1:0] pred_req_pc,
  output logic             pred_resp_valid,
  output logic             pred_taken,
  output logic [WIDTH-1:0] pred_target,
  input  logic             upd_valid,
  input  logic [WIDTH-1:0] upd_pc,
  input  logic             upd_taken,
  input  logic [WIDTH-1:0] upd_target,
  input  logic             upd_pred_taken,
  input  logic [WIDTH-1:0] upd_pred_target,
  output logic             redirect_valid,
  output logic [WIDTH-1:0] redirect_pc,
  output logic [CNT_W-1:0] mispredict_cnt
);

  localparam int ENTRIES = 1 << IDX_W;
  localparam logic [WIDTH-1:0] FOUR = WIDTH'(4);

  logic [ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]   tag_q [ENTRIES];
  logic [WIDTH-1:0]   tgt_q [ENTRIES];
  logic [1:0]         ctr_q [ENTRIES];

  logic [IDX_W-1:0] req_idx;
  logic [IDX_W-1:0] upd_idx;
  logic [TAG_W-1:0] req_tag;
  logic [TAG_W-1:0] upd_tag;

  assign req_idx = pred_req_pc[IDX_W+1:2];
  assign req_tag = pred_req_pc[IDX_W+TAG_W+1:IDX_W+2];
  assign upd_idx = upd_pc[IDX_W+1:2];
  assign upd_tag = upd_pc[IDX_W+TAG_W+1:IDX_W+2];

  logic             req_hit;
  logic             req_tkn;
  logic [WIDTH-1:0] req_next;
  logic             upd_hit;
  logic [WIDTH-1:0] act_next;
  logic [WIDTH-1:0] prd_next;
  logic             mis;

  always_comb begin
    req_hit  = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
    req_tkn  = req_hit && ctr_q[req_idx][1];
    req_next = req_tkn ? tgt_q[req_idx] : pred_req_pc + FOUR;
    upd_hit  = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
    act_next = upd_taken ? upd_target : upd_pc + FOUR;
    prd_next = upd_pred_taken ? upd_pred_target : upd_pc + FOUR;
    mis      = upd_valid && (act_next != prd_next);
  end

  // Table training
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tag_q[i] <= '0;
        tgt_q[i] <= '0;
        ctr_q[i] <= 2'b01;
      end
    end else if (upd_valid) begin
      unique case (1'b1)
        upd_hit && upd_taken: begin
          tgt_q[upd_idx] <= upd_target;
          if (ctr_q[upd_idx] != 2'b11)
            ctr_q[upd_idx] <= ctr_q[upd_idx] + 2'd1;
        end
        upd_hit && !upd_taken: begin
          if (ctr_q[upd_idx] != 2'b00)
            ctr_q[upd_idx] <= ctr_q[upd_idx] - 2'd1;
        end
        !upd_hit && upd_taken: begin
          valid_q[upd_idx] <= 1'b1;
          tag_q[upd_idx]   <= upd_tag;
          tgt_q[upd_idx]   <= upd_target;
          ctr_q[upd_idx]   <= 2'b10;
        end
        default: ;
      endcase
    end
  end

  // Prediction response
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pred_resp_valid <= 1'b0;
      pred_taken      <= 1'b0;
      pred_target     <= '0;
    end else begin
      pred_resp_valid <= pred_req_valid;
      if (pred_req_valid) begin
        pred_taken  <= req_tkn;
        pred_target <= req_next;
      end
    end
  end

  // Redirect and statistics
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      mispredict_cnt <= '0;
    end else begin
      redirect_valid <= mis;
      if (mis) begin
        redirect_pc <= act_next;
        if (mispredict_cnt != '1)
          mispredict_cnt <= mispredict_cnt + CNT_W'(1);
      end
    end
  end

endmodule
